// File: rtl/instr_enc_pkg.sv
// Shared definitions for the RV32 instruction encoder: immediate types (same
// encoding as the core's immediate decoder), field positions, immediate widths.
package instr_enc_pkg;

    typedef enum logic [1:0] {
        IMM_I = 2'd0,
        IMM_S = 2'd1,
        IMM_B = 2'd2,
        IMM_J = 2'd3
    } imm_type_t;

    localparam int OPCODE_LSB = 0;
    localparam int RD_LSB     = 7;
    localparam int FUNCT3_LSB = 12;
    localparam int RS1_LSB    = 15;
    localparam int RS2_LSB    = 20;

    localparam logic [5:0] IMM_W_I = 6'd12;
    localparam logic [5:0] IMM_W_S = 6'd12;
    localparam logic [5:0] IMM_W_B = 6'd13;
    localparam logic [5:0] IMM_W_J = 6'd21;

    typedef struct packed {
        logic [31:0] instr;
        logic        err;
    } enc_word_t;

    // True when imm equals the sign extension of its low w bits.
    function automatic logic imm_fits(input logic [31:0] imm, input logic [5:0] w);
        logic [5:0]         sh;
        logic signed [31:0] t;
        sh = 6'd32 - w;
        t  = $signed(imm) <<< sh;
        t  = t >>> sh;
        return (t == $signed(imm));
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: instruction fields + immediate type -> 32-bit
// encoding and an out-of-range/misaligned flag. Errored words still pack truncated bits.
module instr_pack
    import instr_enc_pkg::*;
(
    input  imm_type_t   imm_type,
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output enc_word_t   word
);

    logic [31:0] instr_s;
    logic        err_s;

    // Place register fields and scatter immediate bits per format.
    always_comb begin
        instr_s = 32'd0;
        err_s   = 1'b0;
        instr_s[OPCODE_LSB +: 7] = opcode;
        case (imm_type)
            IMM_I: begin
                instr_s[RD_LSB +: 5]     = rd;
                instr_s[FUNCT3_LSB +: 3] = funct3;
                instr_s[RS1_LSB +: 5]    = rs1;
                instr_s[31:20]           = imm[11:0];
                err_s = !imm_fits(imm, IMM_W_I);
            end
            IMM_S: begin
                instr_s[FUNCT3_LSB +: 3] = funct3;
                instr_s[RS1_LSB +: 5]    = rs1;
                instr_s[RS2_LSB +: 5]    = rs2;
                instr_s[31:25]           = imm[11:5];
                instr_s[11:7]            = imm[4:0];
                err_s = !imm_fits(imm, IMM_W_S);
            end
            IMM_B: begin
                instr_s[FUNCT3_LSB +: 3] = funct3;
                instr_s[RS1_LSB +: 5]    = rs1;
                instr_s[RS2_LSB +: 5]    = rs2;
                instr_s[31]              = imm[12];
                instr_s[30:25]           = imm[10:5];
                instr_s[11:8]            = imm[4:1];
                instr_s[7]               = imm[11];
                err_s = !imm_fits(imm, IMM_W_B) || imm[0];
            end
            IMM_J: begin
                instr_s[RD_LSB +: 5] = rd;
                instr_s[31]          = imm[20];
                instr_s[30:21]       = imm[10:1];
                instr_s[20]          = imm[11];
                instr_s[19:12]       = imm[19:12];
                err_s = !imm_fits(imm, IMM_W_J) || imm[0];
            end
            default: begin
                instr_s = 32'd0;
                err_s   = 1'b1;
            end
        endcase
    end

    assign word = '{instr: instr_s, err: err_s};

endmodule

// File: rtl/instr_enc.sv
// Streaming RV32 instruction encoder with two-entry output buffer and sequential
// imem address. Define INSTR_ENC_ERR_CNT_EN to add the saturating err_cnt output.
module instr_enc
    import instr_enc_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_type,
    input  logic [6:0]        in_opcode,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_funct3,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    input  logic              err_clr,
    output logic              err_sticky
`ifdef INSTR_ENC_ERR_CNT_EN
    ,
    output logic [7:0]        err_cnt
`endif
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

    enc_word_t         pack_word_s;
    enc_word_t         out_word_r, out_word_nxt_s;
    enc_word_t         skid_word_r, skid_word_nxt_s;
    logic              out_valid_r, out_valid_nxt_s;
    logic              skid_valid_r, skid_valid_nxt_s;
    logic              in_ready_r;
    logic [ADDR_W-1:0] addr_r, addr_nxt_s;
    logic              err_sticky_r, err_sticky_nxt_s;
    logic              acc_s, drain_s, err_hs_s;

    instr_pack u_pack (
        .imm_type (imm_type_t'(in_type)),
        .opcode   (in_opcode),
        .rd       (in_rd),
        .funct3   (in_funct3),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .imm      (in_imm),
        .word     (pack_word_s)
    );

    assign acc_s    = in_valid && in_ready_r;
    assign drain_s  = out_valid_r && out_ready;
    assign err_hs_s = drain_s && out_word_r.err;

    // Buffer next state: skid refills the output first, so FIFO order holds.
    always_comb begin
        out_valid_nxt_s  = out_valid_r;
        out_word_nxt_s   = out_word_r;
        skid_valid_nxt_s = skid_valid_r;
        skid_word_nxt_s  = skid_word_r;
        if (!out_valid_r || drain_s) begin
            if (skid_valid_r) begin
                out_valid_nxt_s  = 1'b1;
                out_word_nxt_s   = skid_word_r;
                skid_valid_nxt_s = acc_s;
                skid_word_nxt_s  = acc_s ? pack_word_s : skid_word_r;
            end else begin
                out_valid_nxt_s  = acc_s;
                out_word_nxt_s   = acc_s ? pack_word_s : out_word_r;
            end
        end else begin
            if (acc_s) begin
                skid_valid_nxt_s = 1'b1;
                skid_word_nxt_s  = pack_word_s;
            end else begin
                skid_valid_nxt_s = skid_valid_r;
                skid_word_nxt_s  = skid_word_r;
            end
        end
    end

    // Address advances per output handshake; the all-ones address wraps to base.
    always_comb begin
        if (drain_s) begin
            addr_nxt_s = (addr_r == LAST_A) ? BASE_A : (addr_r + ONE_A);
        end else begin
            addr_nxt_s = addr_r;
        end
    end

    // Sticky error: a set on this cycle's handshake beats a same-cycle clear.
    always_comb begin
        if (err_hs_s) begin
            err_sticky_nxt_s = 1'b1;
        end else if (err_clr) begin
            err_sticky_nxt_s = 1'b0;
        end else begin
            err_sticky_nxt_s = err_sticky_r;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r  <= 1'b0;
            out_word_r   <= '{instr: 32'd0, err: 1'b0};
            skid_valid_r <= 1'b0;
            skid_word_r  <= '{instr: 32'd0, err: 1'b0};
            in_ready_r   <= 1'b0;
            addr_r       <= BASE_A;
            err_sticky_r <= 1'b0;
        end else begin
            out_valid_r  <= out_valid_nxt_s;
            out_word_r   <= out_word_nxt_s;
            skid_valid_r <= skid_valid_nxt_s;
            skid_word_r  <= skid_word_nxt_s;
            in_ready_r   <= !skid_valid_nxt_s;
            addr_r       <= addr_nxt_s;
            err_sticky_r <= err_sticky_nxt_s;
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign out_instr  = out_word_r.instr;
    assign out_err    = out_word_r.err;
    assign out_addr   = addr_r;
    assign err_sticky = err_sticky_r;

`ifdef INSTR_ENC_ERR_CNT_EN
    logic [7:0] err_cnt_r;

    // Errored-handshake counter: saturates at 255, clear plus increment gives 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_r <= 8'd0;
        end else if (err_clr) begin
            err_cnt_r <= err_hs_s ? 8'd1 : 8'd0;
        end else if (err_hs_s && (err_cnt_r != 8'd255)) begin
            err_cnt_r <= err_cnt_r + 8'd1;
        end else begin
            err_cnt_r <= err_cnt_r;
        end
    end

    assign err_cnt = err_cnt_r;
`endif

endmodule

// File: tb/tb_instr_enc.sv
// Directed self-checking bench for instr_enc (ADDR_W=2 to exercise address wrap).
module tb_instr_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rd;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [1:0]  out_addr;
    logic        out_err;
    logic        err_clr;
    logic        err_sticky;
`ifdef INSTR_ENC_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [1:0]  exp_addr;
    logic        exp_sticky;
    int          exp_cnt;
    int          accepted;
    int          received;
    int          bubbles;
    logic        rdy;
    logic [31:0] w_exp [5] = '{32'h00100093, 32'h00200113, 32'h00300193,
                               32'h00400213, 32'h00500293};

    always #5 clk = ~clk;

    instr_enc #(.ADDR_W(2), .BASE_ADDR(0)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_opcode  (in_opcode),
        .in_rd      (in_rd),
        .in_funct3  (in_funct3),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .in_imm     (in_imm),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_addr   (out_addr),
        .out_err    (out_err),
        .err_clr    (err_clr),
        .err_sticky (err_sticky)
`ifdef INSTR_ENC_ERR_CNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic check_flags();
        check("err_sticky", 32'(err_sticky), 32'(exp_sticky));
`ifdef INSTR_ENC_ERR_CNT_EN
        check("err_cnt", 32'(err_cnt), exp_cnt);
`endif
    endtask

    task automatic drive(input logic [1:0] t, input logic [6:0] op, input logic [4:0] rd,
                         input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm);
        in_type = t; in_opcode = op; in_rd = rd; in_funct3 = f3;
        in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic set_word(input int i);
        drive(2'd0, 7'h13, 5'(i + 1), 3'd0, 5'd0, 5'd0, 32'(i + 1));
    endtask

    // One word through an idle encoder with out_ready=1; optional err_clr at its handshake.
    task automatic do_word(input string tag, input logic [1:0] t, input logic [6:0] op,
                           input logic [4:0] rd, input logic [2:0] f3, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [31:0] imm,
                           input logic [31:0] exp_instr, input logic exp_err, input logic clr);
        @(negedge clk);
        drive(t, op, rd, f3, rs1, rs2, imm);
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !in_ready; n++) @(negedge clk);
        check({tag, "_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_instr"}, out_instr, exp_instr);
        check({tag, "_addr"}, 32'(out_addr), 32'(exp_addr));
        check({tag, "_err"}, 32'(out_err), 32'(exp_err));
        err_clr = clr;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_addr = exp_addr + 2'd1;
        if (exp_err) begin
            exp_sticky = 1'b1;
            exp_cnt = clr ? 1 : ((exp_cnt < 255) ? exp_cnt + 1 : 255);
        end else if (clr) begin
            exp_sticky = 1'b0;
            exp_cnt = 0;
        end
        check({tag, "_drained"}, 32'(out_valid), 32'd0);
        check_flags();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_err", 32'(out_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_addr = 2'd0; exp_sticky = 1'b0; exp_cnt = 0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_addr", 32'(out_addr), 32'd0);
        check_flags();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        drive(2'd0, 7'd0, 5'd0, 3'd0, 5'd0, 5'd0, 32'd0);
        exp_addr = 2'd0; exp_sticky = 1'b0; exp_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_instr", out_instr, 32'd0);
        check("reset_err", 32'(out_err), 32'd0);
        check("reset_ready", 32'(in_ready), 32'd0);
        check("reset_addr", 32'(out_addr), 32'd0);
        check_flags();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("release_ready", 32'(in_ready), 32'd1);

        do_word("addi", 2'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 1'b0);
        do_word("sw",   2'd1, 7'h23, 5'd0, 3'd2, 5'd3, 5'd2, 32'd8, 32'h0021A423, 1'b0, 1'b0);
        do_word("beq",  2'd2, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0, 1'b0);
        do_word("jal",  2'd3, 7'h6F, 5'd1, 3'd0, 5'd0, 5'd0, 32'h00000800, 32'h001000EF, 1'b0, 1'b0);
        do_word("i2048", 2'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd2048, 32'h80000093, 1'b1, 1'b0);
        do_word("im2048", 2'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'hFFFFF800, 32'h80000093, 1'b0, 1'b0);

        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_sticky = 1'b0; exp_cnt = 0;
        check_flags();

        do_word("b3clr", 2'd2, 7'h63, 5'd0, 3'd0, 5'd1, 5'd2, 32'd3, 32'h00208163, 1'b1, 1'b1);

        // Backpressure: two words fill output + skid, third is held off.
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = 1'b1;
            set_word(accepted);
            rdy = in_ready;
            @(posedge clk);
            if (rdy) accepted++;
        end
        @(negedge clk);
        check("bp_accepted", accepted, 32'd2);
        check("bp_ready", 32'(in_ready), 32'd0);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_hold_instr", out_instr, w_exp[0]);
        check("bp_hold_addr", 32'(out_addr), 32'd0);

        // Drain in order at one word per cycle, addresses wrapping 3 -> 0.
        out_ready = 1'b1;
        received = 0;
        bubbles = 0;
        for (int c = 0; c < 30 && received < 5; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid) begin
                check("stream_instr", out_instr, w_exp[received]);
                check("stream_addr", 32'(out_addr), 32'(exp_addr));
                received++;
                exp_addr = exp_addr + 2'd1;
            end else begin
                bubbles++;
            end
            in_valid = (accepted < 5);
            if (accepted < 5) set_word(accepted);
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) accepted++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("stream_count", received, 32'd5);
        check("stream_bubbles", bubbles, 32'd0);

        // Reset with both entries occupied discards them and restarts at base.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            in_valid = 1'b1;
            set_word(c);
            @(posedge clk);
        end
        @(negedge clk);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_valid", 32'(out_valid), 32'd1);
        do_reset();
        out_ready = 1'b1;
        do_word("after_rst", 2'd0, 7'h13, 5'd1, 3'd0, 5'd0, 5'd0, 32'd5, 32'h00500093, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
